// File: rtl/i2s_dac_transmitter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_dac_transmitter_pkg
//  Purpose  : Shared audio DAC constants and frame-length helper.
//  Revision : 1.0  initial release
// ============================================================================
package i2s_dac_transmitter_pkg;

    localparam int DAC_WIDTH = 24;
    localparam int SCLK_DIV  = 8;
    localparam int FS_RATIO  = 384;

    function automatic int frame_clocks(input int width, input int div);
        return 2 * width * div;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_bit_timer
//  Purpose  : Bit/slot position counter; presents the position being entered.
//  Revision : 1.0  initial release
// ============================================================================
module i2s_bit_timer #(
    parameter  int WIDTH    = 24,
    parameter  int SCLK_DIV = 8,
    localparam int CW       = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1,
    localparam int SW       = $clog2(2 * WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable_i,
    output logic [SW-1:0] slot_nxt_o,
    output logic [CW-1:0] cnt_nxt_o,
    output logic          run_o,
    output logic          frame_entry_o,
    output logic          sclk_nxt_o
);
    import i2s_dac_transmitter_pkg::*;

    localparam logic [CW-1:0] C_CNT_LAST  = CW'(SCLK_DIV - 1);
    localparam logic [CW-1:0] C_CNT_HALF  = CW'(SCLK_DIV / 2);
    localparam logic [SW-1:0] C_SLOT_LAST = SW'(2 * WIDTH - 1);

    logic [CW-1:0] cnt_q,  cnt_d;
    logic [SW-1:0] slot_q, slot_d;
    logic          idle_q, idle_d;
    logic          w_run;
    logic          w_entry;

    always_comb begin
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        idle_d  = idle_q;
        w_run   = 1'b0;
        w_entry = 1'b0;
        if (reset || !enable_i) begin
            cnt_d  = '0;
            slot_d = '0;
            idle_d = 1'b1;
        end else if (idle_q) begin
            cnt_d   = '0;
            slot_d  = '0;
            idle_d  = 1'b0;
            w_run   = 1'b1;
            w_entry = 1'b1;
        end else begin
            w_run = 1'b1;
            if (cnt_q == C_CNT_LAST) begin
                cnt_d = '0;
                if (slot_q == C_SLOT_LAST) begin
                    slot_d  = '0;
                    w_entry = 1'b1;
                end else begin
                    slot_d = slot_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            slot_q <= '0;
            idle_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            slot_q <= slot_d;
            idle_q <= idle_d;
        end
    end

    assign slot_nxt_o    = slot_d;
    assign cnt_nxt_o     = cnt_d;
    assign run_o         = w_run;
    assign frame_entry_o = w_entry;
    assign sclk_nxt_o    = w_run && (cnt_d >= C_CNT_HALF);

endmodule
`default_nettype wire

// File: rtl/i2s_dac_transmitter.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_dac_transmitter
//  Purpose  : Philips I2S serialiser for one stereo sample pair per frame.
//  Revision : 1.0  initial release
// ============================================================================
module i2s_dac_transmitter #(
    parameter  int WIDTH    = i2s_dac_transmitter_pkg::DAC_WIDTH,
    parameter  int SCLK_DIV = i2s_dac_transmitter_pkg::SCLK_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] left_data,
    input  logic [WIDTH-1:0] right_data,
    output logic             frame_start,
    output logic             sclk,
    output logic             lrclk,
    output logic             sd
);
    import i2s_dac_transmitter_pkg::*;

    localparam int CW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int SW = $clog2(2 * WIDTH);
    localparam int IW = SW + 1;

    logic [SW-1:0]    w_slot_d;
    logic [CW-1:0]    w_cnt_d;
    logic             w_run;
    logic             w_entry;
    logic             w_sclk_d;
    logic             w_lrclk_d;
    logic             w_sd_d;
    logic [IW-1:0]    w_slot_ext;
    logic [IW-1:0]    w_lidx;
    logic [IW-1:0]    w_ridx;
    logic [WIDTH-1:0] w_left_sh;
    logic [WIDTH-1:0] w_right_sh;

    logic [WIDTH-1:0] left_hold_q;
    logic [WIDTH-1:0] right_hold_q;
    logic             right_lsb_prev_q;
    logic             entry_q;
    logic             frame_start_q;
    logic             sclk_q;
    logic             lrclk_q;
    logic             sd_q;

    i2s_bit_timer #(
        .WIDTH    (WIDTH),
        .SCLK_DIV (SCLK_DIV)
    ) u_timer (
        .clk           (clk),
        .reset         (reset),
        .enable_i      (enable),
        .slot_nxt_o    (w_slot_d),
        .cnt_nxt_o     (w_cnt_d),
        .run_o         (w_run),
        .frame_entry_o (w_entry),
        .sclk_nxt_o    (w_sclk_d)
    );

    // Slot s carries bit (WIDTH-s) of the left word or (2*WIDTH-s) of the right.
    assign w_slot_ext = {1'b0, w_slot_d};
    assign w_lidx     = IW'(WIDTH) - w_slot_ext;
    assign w_ridx     = IW'(2 * WIDTH) - w_slot_ext;
    assign w_left_sh  = left_hold_q >> w_lidx;
    assign w_right_sh = right_hold_q >> w_ridx;
    assign w_lrclk_d  = w_run && (w_slot_d >= SW'(WIDTH));

    always_comb begin
        w_sd_d = 1'b0;
        if (w_run) begin
            if (w_slot_d == '0) begin
                // On frame entry the LSB register is being loaded this same edge.
                w_sd_d = w_entry ? right_hold_q[0] : right_lsb_prev_q;
            end else if (w_slot_d <= SW'(WIDTH)) begin
                w_sd_d = w_left_sh[0];
            end else begin
                w_sd_d = w_right_sh[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            left_hold_q      <= '0;
            right_hold_q     <= '0;
            right_lsb_prev_q <= 1'b0;
            entry_q          <= 1'b0;
            frame_start_q    <= 1'b0;
            sclk_q           <= 1'b0;
            lrclk_q          <= 1'b0;
            sd_q             <= 1'b0;
        end else begin
            entry_q       <= w_entry;
            frame_start_q <= enable && entry_q;
            sclk_q        <= w_sclk_d;
            lrclk_q       <= w_lrclk_d;
            sd_q          <= w_sd_d;
            if (w_entry) begin
                left_hold_q      <= left_data;
                right_hold_q     <= right_data;
                right_lsb_prev_q <= right_hold_q[0];
            end
        end
    end

    assign frame_start = frame_start_q;
    assign sclk        = sclk_q;
    assign lrclk       = lrclk_q;
    assign sd          = sd_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_dac_transmitter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2s_dac_transmitter
//  Purpose  : Directed self-checking bench for the I2S DAC transmitter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_i2s_dac_transmitter;

    logic        clk = 1'b0;
    logic        reset, enable;
    logic [23:0] left, right;
    logic        fs, sclk, lrclk, sd;

    logic        s_reset, s_enable;
    logic [3:0]  s_left, s_right;
    logic        s_fs, s_sclk, s_lrclk, s_sd;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [47:0] exp_a, exp_b, exp_c, exp_d, exp_e;
    logic [8:0]  exp_s;

    always #5 clk = ~clk;

    i2s_dac_transmitter dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .left_data   (left),
        .right_data  (right),
        .frame_start (fs),
        .sclk        (sclk),
        .lrclk       (lrclk),
        .sd          (sd)
    );

    i2s_dac_transmitter #(.WIDTH(4), .SCLK_DIV(2)) dut_s (
        .clk         (clk),
        .reset       (s_reset),
        .enable      (s_enable),
        .left_data   (s_left),
        .right_data  (s_right),
        .frame_start (s_fs),
        .sclk        (s_sclk),
        .lrclk       (s_lrclk),
        .sd          (s_sd)
    );

    task automatic chk(input string tag, input logic obs, input logic expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic edge_sample();
        @(posedge clk);
        @(negedge clk);
    endtask

    // k = clocks since frame entry in the default-parameter instance.
    task automatic check_pos(input string nm, input int k, input logic [47:0] expv);
        chk($sformatf("%s_sclk_k%0d", nm, k),  sclk,  (k % 8) >= 4);
        chk($sformatf("%s_lrclk_k%0d", nm, k), lrclk, (k / 8) >= 24);
        chk($sformatf("%s_fs_k%0d", nm, k),    fs,    k == 1);
        chk($sformatf("%s_sd_k%0d", nm, k),    sd,    expv[k / 8]);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_sclk"},  sclk,  1'b0);
        chk({nm, "_lrclk"}, lrclk, 1'b0);
        chk({nm, "_sd"},    sd,    1'b0);
        chk({nm, "_fs"},    fs,    1'b0);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; left = '0; right = '0;
        s_reset = 1'b1; s_enable = 1'b0; s_left = '0; s_right = '0;

        exp_a = '0;
        exp_a[1]  = 1'b1;
        exp_a[24] = 1'b1;
        for (int s = 26; s < 48; s++) exp_a[s] = 1'b1;
        exp_b = 48'h1;
        exp_c = 48'h0;
        exp_d = 48'h3;
        exp_e = 48'h2;
        exp_s = 9'b1_0100_1010;

        repeat (3) edge_sample();
        check_zero("reset");

        enable = 1'b1;
        edge_sample();
        check_zero("rst_prio");

        // Frame 1: inputs swapped to zero in slot 10 must not disturb it.
        left = 24'h800001; right = 24'h7FFFFF; reset = 1'b0;
        for (int k = 0; k < 384; k++) begin
            edge_sample();
            check_pos("f1", k, exp_a);
            if (k == 80) begin left = '0; right = '0; end
        end

        // Frame 2: zeros latched; slot 0 carries the previous right LSB.
        for (int k = 0; k < 384; k++) begin
            edge_sample();
            check_pos("f2", k, exp_b);
            if (k == 80) begin left = '0; right = 24'h000001; end
        end

        // Frame 3 until slot 30, then enable drops for 50 clocks.
        for (int k = 0; k <= 240; k++) begin
            edge_sample();
            check_pos("f3", k, exp_c);
        end
        enable = 1'b0;
        for (int i = 0; i < 50; i++) begin
            edge_sample();
            check_zero($sformatf("dis%0d", i));
            if (i == 0) begin left = 24'h800000; right = 24'h000001; end
        end
        enable = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            edge_sample();
            check_pos("rs", k, exp_d);
        end

        // Reset mid-frame with enable still high.
        reset = 1'b1;
        edge_sample();
        check_zero("mid_rst");
        reset = 1'b0;
        for (int k = 0; k < 32; k++) begin
            edge_sample();
            check_pos("ar", k, exp_e);
        end

        // Reduced instance: WIDTH=4, SCLK_DIV=2.
        s_left = 4'hA; s_right = 4'h5; s_enable = 1'b1; s_reset = 1'b0;
        for (int k = 0; k < 18; k++) begin
            edge_sample();
            chk($sformatf("sm_sclk_k%0d", k),  s_sclk,  (k % 2) == 1);
            chk($sformatf("sm_lrclk_k%0d", k), s_lrclk, ((k % 16) / 2) >= 4);
            chk($sformatf("sm_fs_k%0d", k),    s_fs,    (k % 16) == 1);
            chk($sformatf("sm_sd_k%0d", k),    s_sd,    exp_s[k / 2]);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
